// File: rtl/reg_cmd_pkg.sv
// Shared constants and FSM state type for the UART-to-register-file command controller.
// The ACK state exists only when REG_CMD_WR_ACK_EN is defined.
package reg_cmd_pkg;

   localparam logic [7:0] CMD_WR = 8'hAA;
   localparam logic [7:0] CMD_RD = 8'hBB;
   localparam logic [7:0] WR_ACK = 8'h5A;

   localparam int unsigned RD_WAIT_LIMIT = 2;

   typedef enum logic [3:0] {
      IDLE,
      WR_ADDR,
      WR_DATA,
      WR_EXEC,
      RD_ADDR,
      RD_EXEC,
      RD_WAIT,
      TX_SEND
`ifdef REG_CMD_WR_ACK_EN
      , ACK
`endif
   } state_t;

endpackage

// File: rtl/reg_cmd_timeout.sv
// Inter-byte inactivity counter for a frame in progress; TIMEOUT = 0 disables expiry.
module reg_cmd_timeout #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

   logic [CW-1:0] count;

   // Saturates at LIMIT so a stalled count never wraps back to zero.
   always_ff @(posedge clk) begin
      if (rst || clear)
         count <= '0;
      else if (enable && (count != LIMIT))
         count <= count + 1'b1;
   end

   assign expired = (TIMEOUT != 0) && enable && !clear && (count == LIMIT);

endmodule

// File: rtl/reg_cmd_ctrl.sv
// Parses UART RX bytes into register-file write (AA addr data) and read (BB addr) frames.
// Define REG_CMD_WR_ACK_EN to acknowledge each write with a 0x5A byte on the TX handshake.
module reg_cmd_ctrl
   import reg_cmd_pkg::*;
#(
   parameter  int unsigned WIDTH   = 8,
   parameter  int unsigned DEPTH   = 16,
   parameter  int unsigned TIMEOUT = 255,
   localparam int unsigned ADDR_W  = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              RST,
   input  logic [WIDTH-1:0]  RX_P_DATA,
   input  logic              RX_D_VLD,
   output logic              WrEn,
   output logic              RdEn,
   output logic [ADDR_W-1:0] Address,
   output logic [WIDTH-1:0]  WrData,
   input  logic [WIDTH-1:0]  RdData,
   input  logic              RdData_Valid,
   output logic [WIDTH-1:0]  TX_P_DATA,
   output logic              TX_D_VLD,
   input  logic              TX_READY,
   output logic              ERR
);

   localparam logic [WIDTH-1:0] CMD_WR_W = WIDTH'(CMD_WR);
   localparam logic [WIDTH-1:0] CMD_RD_W = WIDTH'(CMD_RD);
   localparam logic [WIDTH:0]   DEPTH_LIM = (WIDTH + 1)'(DEPTH);

   state_t            state, state_d;
   logic              wr_en_d, rd_en_d, tx_vld_d, err_d;
   logic [ADDR_W-1:0] addr_d;
   logic [WIDTH-1:0]  wr_data_d, tx_data_d;
   logic [1:0]        wait_cnt;
   logic              in_frame, expired, addr_ok;

   assign in_frame = (state == WR_ADDR) || (state == WR_DATA) || (state == RD_ADDR);
   assign addr_ok  = {1'b0, RX_P_DATA} < DEPTH_LIM;

   reg_cmd_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
      .clk     (clk),
      .rst     (RST),
      .clear   (RX_D_VLD || !in_frame),
      .enable  (in_frame),
      .expired (expired)
   );

   // Outputs are registered from next-state values, so each strobe lands
   // exactly one cycle after the RX byte that caused it.
   always_comb begin
      state_d   = state;
      wr_en_d   = 1'b0;
      rd_en_d   = 1'b0;
      err_d     = 1'b0;
      addr_d    = Address;
      wr_data_d = WrData;
      tx_data_d = TX_P_DATA;
      tx_vld_d  = TX_D_VLD;
      case (state)
         IDLE: begin
            if (RX_D_VLD) begin
               if (RX_P_DATA == CMD_WR_W)      state_d = WR_ADDR;
               else if (RX_P_DATA == CMD_RD_W) state_d = RD_ADDR;
               else                            err_d   = 1'b1;
            end
         end
         WR_ADDR, RD_ADDR: begin
            if (RX_D_VLD) begin
               if (addr_ok) begin
                  addr_d = RX_P_DATA[ADDR_W-1:0];
                  if (state == WR_ADDR) begin
                     state_d = WR_DATA;
                  end else begin
                     state_d = RD_EXEC;
                     rd_en_d = 1'b1;
                  end
               end else begin
                  err_d   = 1'b1;
                  state_d = IDLE;
               end
            end else if (expired) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end
         end
         WR_DATA: begin
            if (RX_D_VLD) begin
               wr_data_d = RX_P_DATA;
               wr_en_d   = 1'b1;
               state_d   = WR_EXEC;
            end else if (expired) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end
         end
         WR_EXEC: begin
            err_d = RX_D_VLD;
`ifdef REG_CMD_WR_ACK_EN
            tx_data_d = WIDTH'(WR_ACK);
            tx_vld_d  = 1'b1;
            state_d   = ACK;
`else
            state_d   = IDLE;
`endif
         end
         RD_EXEC: begin
            err_d   = RX_D_VLD;
            state_d = RD_WAIT;
         end
         RD_WAIT: begin
            err_d = RX_D_VLD;
            if (RdData_Valid) begin
               tx_data_d = RdData;
               tx_vld_d  = 1'b1;
               state_d   = TX_SEND;
            end else if (wait_cnt == 2'(RD_WAIT_LIMIT - 1)) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end
         end
`ifdef REG_CMD_WR_ACK_EN
         TX_SEND, ACK: begin
`else
         TX_SEND: begin
`endif
            err_d = RX_D_VLD;
            if (TX_READY) begin
               tx_vld_d = 1'b0;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (RST) begin
         state     <= IDLE;
         WrEn      <= 1'b0;
         RdEn      <= 1'b0;
         Address   <= '0;
         WrData    <= '0;
         TX_P_DATA <= '0;
         TX_D_VLD  <= 1'b0;
         ERR       <= 1'b0;
         wait_cnt  <= '0;
      end else begin
         state     <= state_d;
         WrEn      <= wr_en_d;
         RdEn      <= rd_en_d;
         Address   <= addr_d;
         WrData    <= wr_data_d;
         TX_P_DATA <= tx_data_d;
         TX_D_VLD  <= tx_vld_d;
         ERR       <= err_d;
         wait_cnt  <= (state == RD_WAIT) ? wait_cnt + 1'b1 : '0;
      end
   end

endmodule
